// File: rtl/pc_gen_btb.sv
// Fetch-address generator with a direct-mapped BTB of 2-bit saturating counters.
// Define PC_BTB_EN to build the BTB; without it the block predicts static not-taken.
module pc_gen_btb #(
   parameter int unsigned       ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
   parameter int unsigned       BTB_ENTRIES = 16,
   parameter int unsigned       INSTR_BYTES = 4
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] fetch_pc,
   output logic              fetch_valid,
   input  logic              fetch_ready,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target
);

   typedef enum logic {BOOT, RUN} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              unused_ok;

   assign fetch_pc    = pc_q;
   assign fetch_valid = (state_q == RUN);

`ifdef PC_BTB_EN
   localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
   localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

   logic [BTB_ENTRIES-1:0] vld_q;
   logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
   logic [ADDR_W-1:0]      tgt_q [BTB_ENTRIES];
   logic [1:0]             ctr_q [BTB_ENTRIES];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             lk_hit, up_hit;

   assign lk_idx      = pc_q[IDX_W+1:2];
   assign lk_hit      = vld_q[lk_idx] && (tag_q[lk_idx] == pc_q[ADDR_W-1:IDX_W+2]);
   assign pred_taken  = fetch_valid && lk_hit && ctr_q[lk_idx][1];
   assign pred_target = tgt_q[lk_idx];

   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
   assign up_hit = vld_q[up_idx] && (tag_q[up_idx] == up_tag);

   assign unused_ok = ^{redirect_pc[0], upd_pc[1:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         vld_q <= '0;
      else if (upd_valid && upd_taken && !up_hit)
         vld_q[up_idx] <= 1'b1;
   end

   // Payload is left unreset; valid bits alone decide whether an entry is live.
   always_ff @(posedge clk) begin
      if (upd_valid && !reset) begin
         if (up_hit) begin
            if (upd_taken) begin
               ctr_q[up_idx] <= (ctr_q[up_idx] == 2'd3) ? 2'd3 : ctr_q[up_idx] + 2'd1;
               tgt_q[up_idx] <= {upd_target[ADDR_W-1:1], 1'b0};
            end else begin
               ctr_q[up_idx] <= (ctr_q[up_idx] == 2'd0) ? 2'd0 : ctr_q[up_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= {upd_target[ADDR_W-1:1], 1'b0};
            ctr_q[up_idx] <= 2'd2;
         end
      end
   end
`else
   assign pred_taken  = 1'b0;
   assign pred_target = '0;
   assign unused_ok   = ^{redirect_pc[0], upd_valid, upd_pc, upd_taken, upd_target,
                          1'(BTB_ENTRIES)};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_VEC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Redirect beats prediction beats sequential advance; a stalled fetch holds.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (state_q == BOOT)
         state_d = RUN;
      if (redirect)
         pc_d = {redirect_pc[ADDR_W-1:1], 1'b0};
      else if (fetch_valid && fetch_ready)
         pc_d = pred_taken ? pred_target : pc_q + ADDR_W'(INSTR_BYTES);
   end

endmodule
